// File: rtl/gl_raster_scheduler_pkg.sv
// Shared types and constants for the triangle rasterizer scheduler:
// vertex layout, scheduler state encoding and the default watchdog limit.
package gl_raster_pkg;

  // Vertex layout: x = [95:64], y = [63:32] (fp32 each).
  localparam int VERTEX_TYPE_SIZE = 96;
  localparam int X_MSB = 95;
  localparam int X_LSB = 64;
  localparam int Y_MSB = 63;
  localparam int Y_LSB = 32;

  // Watchdog limit in WAIT and the width of its counter.
  localparam int TIMEOUT_CYCLES_DEF = 1048575;
  localparam int TIMER_W = 20;

  // Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/gl_raster_scheduler_if.sv
// Source-side and rasterizer-side handshake bundle of the scheduler.
// master: the scheduler; slave: the environment (vertex FIFOs + rasterizer).
interface gl_raster_scheduler_if #(
  parameter int NUM_SRC          = 4,
  parameter int VERTEX_TYPE_SIZE = gl_raster_pkg::VERTEX_TYPE_SIZE
);
  logic [NUM_SRC-1:0]                    src_valid;
  logic [NUM_SRC-1:0]                    src_ready;
  logic [NUM_SRC*3*VERTEX_TYPE_SIZE-1:0] src_tri;
  logic                                  rast_start;
  logic [VERTEX_TYPE_SIZE-1:0]           rast_v1;
  logic [VERTEX_TYPE_SIZE-1:0]           rast_v2;
  logic [VERTEX_TYPE_SIZE-1:0]           rast_v3;
  logic                                  rast_done;

  modport master (
    input  src_valid, src_tri, rast_done,
    output src_ready, rast_start, rast_v1, rast_v2, rast_v3
  );

  modport slave (
    output src_valid, src_tri, rast_done,
    input  src_ready, rast_start, rast_v1, rast_v2, rast_v3
  );
endinterface

// File: rtl/gl_raster_scheduler_arb.sv
// Combinational round-robin arbiter: searches from last_i+1 upward,
// wrapping modulo NUM_SRC, and grants the first requester (one-hot + index).
module gl_rr_arbiter #(
  parameter  int NUM_SRC = 4,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  input  logic               en_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  int               pos_s;
  logic [IDX_W-1:0] pos_idx_s;
  logic             found_s;

  // Rotating priority scan; the just-served source is checked last.
  always_comb begin
    gnt_o     = '0;
    idx_o     = '0;
    found_s   = 1'b0;
    pos_s     = 0;
    pos_idx_s = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      pos_s     = (int'(last_i) + k) % NUM_SRC;
      pos_idx_s = IDX_W'(pos_s);
      if (en_i && !found_s && req_i[pos_idx_s]) begin
        found_s          = 1'b1;
        gnt_o[pos_idx_s] = 1'b1;
        idx_o            = pos_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/gl_raster_scheduler.sv
// Shares one triangle rasterizer between NUM_SRC triangle producers.
// IDLE: round-robin accept of one triangle; ISSUE: one-cycle start pulse;
// WAIT: hold vertices until the rasterizer's completion pulse.
// Optional watchdog in WAIT: define GL_RASTER_SCHED_TIMEOUT_EN.
module gl_raster_scheduler #(
  parameter  int NUM_SRC          = 4,
  parameter  int VERTEX_TYPE_SIZE = gl_raster_pkg::VERTEX_TYPE_SIZE,
  parameter  int TIMEOUT_CYCLES   = gl_raster_pkg::TIMEOUT_CYCLES_DEF,
  localparam int IDX_W            = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gl_raster_scheduler_if.master bus,
  output logic                  busy,
  output logic [IDX_W-1:0]      grant_id,
  output logic [31:0]           tri_count,
  output logic                  timeout_err
);
  import gl_raster_pkg::*;

  localparam int TRI_W = 3 * VERTEX_TYPE_SIZE;

  sched_state_t                state_q, state_d;
  logic [IDX_W-1:0]            last_grant_q, last_grant_d;
  logic [IDX_W-1:0]            grant_id_q, grant_id_d;
  logic [VERTEX_TYPE_SIZE-1:0] v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [31:0]                 tri_count_q, tri_count_d;
  logic                        timeout_err_q, timeout_err_d;
  logic                        rast_start_q, busy_q;

  logic [NUM_SRC-1:0]          arb_gnt_s;
  logic [IDX_W-1:0]            arb_idx_s;
  logic                        xfer_s;
  logic [TRI_W-1:0]            win_tri_s;

`ifdef GL_RASTER_SCHED_TIMEOUT_EN
  logic [TIMER_W-1:0]          timer_q, timer_d;
`else
  logic                        unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES >= (1 << TIMER_W));
`endif

  gl_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req_i  (bus.src_valid),
    .last_i (last_grant_q),
    .en_i   (state_q == IDLE),
    .gnt_o  (arb_gnt_s),
    .idx_o  (arb_idx_s)
  );

  // A grant is only ever issued to a valid source, so any grant is a transfer.
  assign xfer_s        = |(arb_gnt_s & bus.src_valid);
  assign bus.src_ready = arb_gnt_s;

  // Select the winning source's triangle slice.
  always_comb begin
    win_tri_s = bus.src_tri[int'(arb_idx_s)*TRI_W +: TRI_W];
  end

  // Next-state and datapath update for the IDLE/ISSUE/WAIT sequence.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    v1_d          = v1_q;
    v2_d          = v2_q;
    v3_d          = v3_q;
    tri_count_d   = tri_count_q;
    timeout_err_d = timeout_err_q;
`ifdef GL_RASTER_SCHED_TIMEOUT_EN
    timer_d       = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          v1_d         = win_tri_s[VERTEX_TYPE_SIZE-1:0];
          v2_d         = win_tri_s[2*VERTEX_TYPE_SIZE-1:VERTEX_TYPE_SIZE];
          v3_d         = win_tri_s[TRI_W-1:2*VERTEX_TYPE_SIZE];
          grant_id_d   = arb_idx_s;
          last_grant_d = arb_idx_s;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef GL_RASTER_SCHED_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      WAIT: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (bus.rast_done) begin
          tri_count_d = tri_count_q + 32'd1;
          state_d     = IDLE;
        end else begin
`ifdef GL_RASTER_SCHED_TIMEOUT_EN
          if ((timer_q + TIMER_W'(32'd1)) == TIMER_W'(TIMEOUT_CYCLES)) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end else begin
            timer_d = timer_q + TIMER_W'(32'd1);
            state_d = WAIT;
          end
`else
          state_d = WAIT;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, round-robin pointer, vertex latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= IDX_W'(NUM_SRC - 1);
      grant_id_q    <= '0;
      v1_q          <= '0;
      v2_q          <= '0;
      v3_q          <= '0;
      tri_count_q   <= 32'd0;
      timeout_err_q <= 1'b0;
      rast_start_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      v1_q          <= v1_d;
      v2_q          <= v2_d;
      v3_q          <= v3_d;
      tri_count_q   <= tri_count_d;
      timeout_err_q <= timeout_err_d;
      rast_start_q  <= (state_d == ISSUE);
      busy_q        <= (state_d == ISSUE) || (state_d == WAIT);
    end
  end

`ifdef GL_RASTER_SCHED_TIMEOUT_EN
  // Watchdog counter of WAIT cycles without completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign bus.rast_start = rast_start_q;
  assign bus.rast_v1    = v1_q;
  assign bus.rast_v2    = v2_q;
  assign bus.rast_v3    = v3_q;
  assign busy           = busy_q;
  assign grant_id       = grant_id_q;
  assign tri_count      = tri_count_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_gl_raster_scheduler.sv
// Scoreboard bench for gl_raster_scheduler: a reference model predicts the
// round-robin winner and pushes the expected triangle when stimulus is
// accepted; entries are popped and compared when rast_start is observed.
module tb_gl_raster_scheduler;
  import gl_raster_pkg::*;

  localparam int N     = 4;
  localparam int V     = 96;
  localparam int TRI_W = 3 * V;
  localparam int TO    = 16;

  typedef struct packed {
    logic [1:0]       id;
    logic [TRI_W-1:0] tri_v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [1:0]  grant_id;
  logic [31:0] tri_count;
  logic        timeout_err;

  gl_raster_scheduler_if #(.NUM_SRC(N), .VERTEX_TYPE_SIZE(V)) bus_if ();

  gl_raster_scheduler #(
    .NUM_SRC(N), .VERTEX_TYPE_SIZE(V), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .busy        (busy),
    .grant_id    (grant_id),
    .tri_count   (tri_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       sb_q[$];
  int         grant_log[$];
  int         exp_q[$];
  int         seen_rdy[N] = '{default: 0};
  int         credit[N]   = '{default: 0};
  int         accepted[N] = '{default: 0};
  logic [N-1:0] acc_mask  = '0;
  int         pulse_seq = 0, pulse_ack = 0, issue_seq = 0, issue_ack = 0;
  bit         auto_done = 1'b0;
  int         done_dly  = 5;
  int         done_cnt  = 0;

  sched_state_t m_state = IDLE;
  int           m_last  = N - 1;
  int           m_wait  = 0;
  logic [31:0]  m_count = 32'd0;
  logic         m_terr  = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TRI_W-1:0] rand_tri();
    logic [TRI_W-1:0] r;
    for (int w = 0; w < 9; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit all_consumed();
    for (int i = 0; i < N; i++) if (credit[i] != accepted[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Input driver: src_valid/src_tri from credits, rast_done from responder/pulses.
  initial begin
    logic [TRI_W-1:0] tmp;
    logic [N-1:0]     vmask;
    logic             rd;
    bus_if.src_valid = '0;
    bus_if.rast_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      tmp = rand_tri();
      if (i == 0) begin
        tmp[X_MSB:X_LSB] = 32'h3F80_0000;
        tmp[Y_MSB:Y_LSB] = 32'h4000_0000;
      end
      bus_if.src_tri[i*TRI_W +: TRI_W] = tmp;
    end
    forever begin
      @(posedge clk);
      #1;
      rd = 1'b0;
      if (!rst_n) done_cnt = 0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) rd = 1'b1;
      end
      if (pulse_seq != pulse_ack) begin
        rd = 1'b1;
        pulse_ack = pulse_seq;
      end
      if (acc_mask != '0) begin
        for (int i = 0; i < N; i++) begin
          if (acc_mask[i]) begin
            accepted[i]++;
            bus_if.src_tri[i*TRI_W +: TRI_W] = rand_tri();
          end
        end
        if (issue_seq != issue_ack) begin
          rd = 1'b1;
          issue_ack = issue_seq;
        end
        if (auto_done) done_cnt = done_dly;
      end
      bus_if.rast_done = rd;
      for (int i = 0; i < N; i++) vmask[i] = (credit[i] != accepted[i]);
      bus_if.src_valid = vmask;
    end
  end

  // Monitor + reference model, sampled on the falling edge.
  initial begin
    int           w;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_state = IDLE; m_last = N - 1; m_count = 32'd0; m_terr = 1'b0;
        sb_q.delete();
        acc_mask = '0;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_start", bus_if.rast_start, 1'b0);
        check_eq("rst_count", tri_count, 32'd0);
      end else begin
        acc_mask = bus_if.src_valid & bus_if.src_ready;
        check_eq("busy", busy, (m_state != IDLE));
        check_eq("rast_start", bus_if.rast_start, (m_state == ISSUE));
        check_eq("tri_count", tri_count, m_count);
        check_eq("timeout_err", timeout_err, m_terr);
        case (m_state)
          IDLE: begin
            w = -1;
            for (int k = 1; k <= N; k++)
              if (w < 0 && bus_if.src_valid[(m_last + k) % N]) w = (m_last + k) % N;
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            check_eq("src_ready", bus_if.src_ready, exp_rdy);
            for (int i = 0; i < N; i++) seen_rdy[i] += int'(bus_if.src_ready[i]);
            if (w >= 0) begin
              e.id    = 2'(w);
              e.tri_v = bus_if.src_tri[w*TRI_W +: TRI_W];
              sb_q.push_back(e);
              m_last  = w;
              m_state = ISSUE;
            end
          end
          ISSUE: begin
            if (sb_q.size() == 0) begin
              check_eq("sb_empty", 1'b1, 1'b0);
            end else begin
              e = sb_q.pop_front();
              check_eq("grant_id", grant_id, e.id);
              check_eq("rast_v1", bus_if.rast_v1, e.tri_v[V-1:0]);
              check_eq("rast_v2", bus_if.rast_v2, e.tri_v[2*V-1:V]);
              check_eq("rast_v3", bus_if.rast_v3, e.tri_v[TRI_W-1:2*V]);
            end
            grant_log.push_back(int'(grant_id));
            m_state = WAIT;
            m_wait  = 0;
          end
          WAIT: begin
            check_eq("wait_ready", bus_if.src_ready, 4'b0000);
            if (bus_if.rast_done) begin
              m_count = m_count + 32'd1;
              m_state = IDLE;
            end else begin
`ifdef GL_RASTER_SCHED_TIMEOUT_EN
              m_wait++;
              if (m_wait == TO) begin
                m_terr  = 1'b1;
                m_state = IDLE;
              end
`endif
            end
          end
          default: m_state = IDLE;
        endcase
      end
    end
  end

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy && all_consumed() && bus_if.src_valid == '0) return;
    end
    check_eq("wait_idle_bound", 1'b1, 1'b0);
  endtask

  task automatic wait_busy(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy) return;
    end
    check_eq("wait_busy_bound", 1'b1, 1'b0);
  endtask

  task automatic check_log(input string tag, input int start);
    check_eq({tag, "_len"}, grant_log.size() - start, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (start + k < grant_log.size())
        check_eq($sformatf("%s_%0d", tag, k), grant_log[start + k], exp_q[k]);
  endtask

  initial begin
    int ls, s0, s2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_gid", grant_id, 2'd0);
    check_eq("reset_v1", bus_if.rast_v1, 96'd0);
    check_eq("reset_terr", timeout_err, 1'b0);
    rst_n = 1'b1;

    // Single triangle from source 0, done 10 cycles after start.
    auto_done = 1'b1; done_dly = 10; credit[0]++;
    wait_idle(100);
    check_eq("t1_v1x", bus_if.rast_v1[X_MSB:X_LSB], 32'h3F80_0000);
    check_eq("t1_gid", grant_id, 2'd0);
    check_eq("t1_count", tri_count, 32'd1);

    // Asynchronous reset in the middle of WAIT.
    auto_done = 1'b0; credit[2]++;
    wait_busy(20);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_start", bus_if.rast_start, 1'b0);
    check_eq("arst_gid", grant_id, 2'd0);
    check_eq("arst_count", tri_count, 32'd0);
    check_eq("arst_v1", bus_if.rast_v1, 96'd0);
    check_eq("arst_v3", bus_if.rast_v3, 96'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_seq++;
    repeat (4) @(negedge clk);
    check_eq("late_done_count", tri_count, 32'd0);
    auto_done = 1'b1; done_dly = 3; ls = grant_log.size();
    credit[0]++; credit[2]++;
    wait_idle(100);
    exp_q = '{0, 2};
    check_log("post_rst_order", ls);
    check_eq("post_rst_count", tri_count, 32'd2);

    // Fresh reset, then all four sources continuously valid.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done_dly = 5; ls = grant_log.size();
    for (int i = 0; i < N; i++) credit[i] += 2;
    wait_idle(400);
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_log("rr_order", ls);
    check_eq("rr_count", tri_count, 32'd8);

    // Only sources 1 and 3 valid after source 3 was last served.
    s0 = seen_rdy[0]; s2 = seen_rdy[2]; ls = grant_log.size();
    credit[1]++; credit[3]++;
    wait_idle(100);
    exp_q = '{1, 3};
    check_log("sparse_order", ls);
    check_eq("sparse_no_rdy0", seen_rdy[0] - s0, 0);
    check_eq("sparse_no_rdy2", seen_rdy[2] - s2, 0);
    check_eq("sparse_count", tri_count, 32'd10);

    // rast_done in IDLE and during ISSUE must not count.
    auto_done = 1'b0;
    pulse_seq++;
    repeat (3) @(negedge clk);
    check_eq("idle_done_count", tri_count, 32'd10);
    issue_seq++; credit[0]++;
    wait_busy(20);
    repeat (6) @(negedge clk);
    check_eq("issue_done_wait", busy, 1'b1);
    check_eq("issue_done_count", tri_count, 32'd10);
    pulse_seq++;
    wait_idle(50);
    check_eq("issue_done_final", tri_count, 32'd11);
    check_eq("issue_done_gid", grant_id, 2'd0);

    // No completion: watchdog (when built) or indefinite WAIT.
    credit[1]++;
`ifdef GL_RASTER_SCHED_TIMEOUT_EN
    wait_idle(60);
    check_eq("to_err", timeout_err, 1'b1);
    check_eq("to_count", tri_count, 32'd11);
    auto_done = 1'b1; done_dly = 2; credit[3]++;
    wait_idle(50);
    check_eq("to_next_gid", grant_id, 2'd3);
    check_eq("to_sticky", timeout_err, 1'b1);
`else
    wait_busy(20);
    repeat (30) @(negedge clk);
    check_eq("hold_busy", busy, 1'b1);
    check_eq("hold_terr", timeout_err, 1'b0);
    pulse_seq++;
    wait_idle(50);
    check_eq("hold_gid", grant_id, 2'd1);
`endif
    check_eq("final_count", tri_count, 32'd12);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
